// File: rtl/tile_stream_filter_pkg.sv
// Shared definitions for the tile stream filter.
//   MODE_ZERO / MODE_DROP : out-of-bound word handling selected per tile
//   filt_state_e          : control states of the filter
//   beats_per_tile()      : input beats in one tile, padding included
package tile_filter_pkg;

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_DROP = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } filt_state_e;

    function automatic int unsigned beats_per_tile(
        input int unsigned tn,
        input int unsigned tr,
        input int unsigned tc,
        input int unsigned head_pad,
        input int unsigned tail_pad
    );
        return tn * tr * (head_pad + tc + tail_pad);
    endfunction

endpackage

// File: rtl/tile_stream_filter_if.sv
// Valid/ready word stream.
//   valid : producer has a word
//   data  : the word
//   ready : consumer accepts; transfer when valid && ready
//   master modport = producer side, slave modport = consumer side
interface tile_stream_filter_if #(
    parameter int unsigned DW = 32
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tile_stream_filter_pos_counter.sv
// Three-level nested position counter (cnt0 fastest).
//   clk, rst : clock, asynchronous active-high reset
//   ena      : advance by one position
//   clr      : return all levels to zero (wins over ena)
//   cnt0..2  : current position, cntK runs 0..MAXK-1
//   last     : combinational, high at the final position
module tile_pos_counter #(
    parameter int unsigned CW   = 16,
    parameter int unsigned MAX0 = 18,
    parameter int unsigned MAX1 = 64,
    parameter int unsigned MAX2 = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          clr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic          last
);
    localparam logic [CW-1:0] TOP0 = CW'(MAX0 - 1);
    localparam logic [CW-1:0] TOP1 = CW'(MAX1 - 1);
    localparam logic [CW-1:0] TOP2 = CW'(MAX2 - 1);

    logic wrap0, wrap1, wrap2;

    assign wrap0 = (cnt0 == TOP0);
    assign wrap1 = (cnt1 == TOP1);
    assign wrap2 = (cnt2 == TOP2);
    assign last  = wrap0 && wrap1 && wrap2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (ena) begin
            if (wrap0) begin
                cnt0 <= '0;
                if (wrap1) begin
                    cnt1 <= '0;
                    cnt2 <= wrap2 ? '0 : cnt2 + CW'(1);
                end else begin
                    cnt1 <= cnt1 + CW'(1);
                end
            end else begin
                cnt0 <= cnt0 + CW'(1);
            end
        end
    end
endmodule

// File: rtl/tile_stream_filter.sv
// Tile stream filter: strips per-row padding beats from a tile-ordered word
// stream and zero-fills or drops words outside the feature-map bounds.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : arms a tile when idle; latches bases and mode
//   tile_base_*       : tile origin (channel, row, column)
//   mode              : MODE_ZERO zero-fills, MODE_DROP drops out-of-bound words
//   in_bus  (slave)   : input words (in_valid / in_data / in_ready)
//   out_bus (master)  : output words (out_valid / out_data / out_ready)
//   busy              : tile armed and not fully consumed
//   tile_done         : one-cycle pulse after the last beat is accepted
//   out_cnt           : words loaded into the output register this tile
module tile_stream_filter
    import tile_filter_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned CW       = 16,
    parameter int unsigned N        = 32,
    parameter int unsigned R        = 64,
    parameter int unsigned C        = 32,
    parameter int unsigned Tn       = 16,
    parameter int unsigned Tr       = 64,
    parameter int unsigned Tc       = 16,
    parameter int unsigned HEAD_PAD = 0,
    parameter int unsigned TAIL_PAD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CW-1:0]           tile_base_n,
    input  logic [CW-1:0]           tile_base_row,
    input  logic [CW-1:0]           tile_base_col,
    input  logic                    mode,
    tile_stream_filter_if.slave     in_bus,
    tile_stream_filter_if.master    out_bus,
    output logic                    busy,
    output logic                    tile_done,
    output logic [CW-1:0]           out_cnt
);
    localparam logic [CW-1:0] TAIL_START = CW'(HEAD_PAD + Tc);
    localparam logic [CW:0]   N_LIM      = (CW+1)'(N);
    localparam logic [CW:0]   R_LIM      = (CW+1)'(R);
    localparam logic [CW:0]   C_LIM      = (CW+1)'(C);

    filt_state_e   state, state_nxt;
    logic          arm;
    logic [CW-1:0] base_n_q, base_row_q, base_col_q;
    logic          mode_q;
    logic [CW-1:0] col, row, ch, tc;
    logic          last;
    logic          accept;
    logic          head_pad, tail_pad, legal, emit;
    logic [DW-1:0] word;

    tile_pos_counter #(
        .CW   (CW),
        .MAX0 (HEAD_PAD + Tc + TAIL_PAD),
        .MAX1 (Tr),
        .MAX2 (Tn)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .ena  (accept),
        .clr  (arm),
        .cnt0 (col),
        .cnt1 (row),
        .cnt2 (ch),
        .last (last)
    );

    // A start during RUN (including the last-beat cycle) is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                arm       = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: if (accept && last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy         = (state == ST_RUN);
    assign in_bus.ready = busy && (!out_bus.valid || out_bus.ready);
    assign accept       = in_bus.valid && in_bus.ready;

    // With no head padding the head test would be a compare against zero.
    if (HEAD_PAD == 0) begin : g_no_head
        assign head_pad = 1'b0;
    end else begin : g_head
        assign head_pad = (col < CW'(HEAD_PAD));
    end
    assign tail_pad = (col >= TAIL_START);
    assign tc       = col - CW'(HEAD_PAD);

    // One extra bit keeps base + offset from wrapping before the compare.
    assign legal = (({1'b0, base_n_q}   + {1'b0, ch})  < N_LIM) &&
                   (({1'b0, base_row_q} + {1'b0, row}) < R_LIM) &&
                   (({1'b0, base_col_q} + {1'b0, tc})  < C_LIM);
    assign emit  = accept && !head_pad && !tail_pad && (legal || mode_q == MODE_ZERO);
    assign word  = legal ? in_bus.data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_n_q   <= '0;
            base_row_q <= '0;
            base_col_q <= '0;
            mode_q     <= MODE_ZERO;
        end else if (arm) begin
            base_n_q   <= tile_base_n;
            base_row_q <= tile_base_row;
            base_col_q <= tile_base_col;
            mode_q     <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_bus.valid <= 1'b0;
            out_bus.data  <= '0;
            out_cnt       <= '0;
            tile_done     <= 1'b0;
        end else begin
            tile_done <= accept && last;
            if (arm) out_cnt <= '0;
            if (emit) begin
                out_bus.valid <= 1'b1;
                out_bus.data  <= word;
                out_cnt       <= out_cnt + CW'(1);
            end else if (out_bus.ready) begin
                out_bus.valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/tile_stream_filter.md
# tile_stream_filter

Parametrised tile-stream filter between the DDR load engine and the on-chip feature-map FIFOs. It tracks each incoming word's position inside a Tn×Tr×(HEAD_PAD+Tc+TAIL_PAD) tile and discards per-row padding beats. Words that fall outside the feature-map bounds are either zero-filled or dropped, selected per tile by `mode`. Unlike the previous fixed-timing filter, it has valid/ready flow control on both sides, head and tail padding, run-time mode, and explicit tile start/done.

## Interface
- DW, 32, data width
- CW, 16, counter/coordinate width; every dimension below must be < 2^CW
- N, 32, total channels
- R, 64, total rows
- C, 32, total columns
- Tn, 16, tile channels
- Tr, 64, tile rows
- Tc, 16, tile columns
- HEAD_PAD, 0, padding beats at the start of each row
- TAIL_PAD, 2, padding beats at the end of each row
---
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches bases and mode, arms a tile
- tile_base_n / tile_base_row / tile_base_col  in  CW  tile origin, sampled on start
- mode  in  1  0 = zero-fill out-of-bound words, 1 = drop them; sampled on start
- in_valid  in  1  upstream word valid
- in_data  in  DW  upstream word
- in_ready  out  1  word accepted when in_valid && in_ready
- out_valid  out  1  output word valid
- out_data  out  DW  output word
- out_ready  in  1  downstream accepts
- busy  out  1  tile armed and not yet fully consumed
- tile_done  out  1  one-cycle pulse at end of tile
- out_cnt  out  CW  words emitted in the current tile (wraps mod 2^CW)

## Operation
- Idle: busy=0, in_ready=0. `start` sets busy=1, clears the counters and out_cnt, and latches the bases and mode.
- Position counters col / row / ch, with col the fastest:
  - col runs 0..HEAD_PAD+Tc+TAIL_PAD-1, row runs 0..Tr-1, ch runs 0..Tn-1.
  - Counters advance only on an accepted input beat.
- Column classification:
  - Pad beat: col < HEAD_PAD or col ≥ HEAD_PAD+Tc.
  - Otherwise tc = col-HEAD_PAD.
- Legal word: base_n+ch < N, base_row+row < R and base_col+tc < C. Comparisons are evaluated at CW+1 bits, so there is no overflow.
- Per accepted beat:
  - Pad beat: consumed, nothing emitted.
  - Legal word: emitted unchanged.
  - Out-of-bound word, mode 0: emitted as 0.
  - Out-of-bound word, mode 1: consumed, nothing emitted.
- Last beat is (ch, row, col) = (Tn-1, Tr-1, last col). After it is accepted, busy clears and tile_done pulses.
- `start` while busy is ignored: bases, mode and counters are unchanged.
- `start` in the same cycle as the last-beat accept is also ignored.
- Input beats while idle are never accepted, because in_ready=0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, tile_done=0, out_cnt=0. Counters are 0.
- Output stage is a single register.
  - in_ready = busy && (!out_valid || out_ready), combinational from out_ready.
  - Latency from input accept to out_valid is 1 cycle.
- out_valid/out_data are held stable while out_valid && !out_ready.
- busy rises the cycle after `start`. in_ready can be high in that same cycle.
- tile_done and the busy fall occur in the cycle after the last beat is accepted.
  - The last emitted word may still be held in the output register at that point; it drains normally.
  - The next `start` is accepted while it drains.
- out_cnt increments on each input accept that loads the output register. It is visible one cycle later, together with out_valid.
- Asynchronous reset mid-tile: the held word is discarded, all outputs return to their reset values, and no tile_done is produced.

## Structure
- Package `tile_filter_pkg` holds:
  - Mode constants MODE_ZERO=1'b0 and MODE_DROP=1'b1.
  - A function computing the beats per tile, Tn*Tr*(HEAD_PAD+Tc+TAIL_PAD).
- Sub-module `tile_pos_counter` is a 3-level nested counter with maxima as parameters. It has inputs ena and clr, outputs cnt0/cnt1/cnt2, and a combinational `last` flag.
- Top level contains the latch registers, legality compare, output register and done logic.

## Test plan
Bench parameters: Tn=2, Tr=2, Tc=4, HEAD_PAD=1, TAIL_PAD=1, N=3, R=3, C=5. One tile is 24 beats; in_data = beat index.

1. Interior tile, base (0,0,0), mode 0, out_ready=1, continuous in_valid. Required: 16 outputs equal to indices 1-4, 7-10, 13-16, 19-22; tile_done one cycle after the 24th accept; out_cnt=16.
2. Edge tile, base (2,2,4), mode 0. Required: 16 outputs; only the first output (index 1) is nonzero, all others are 0.
3. Same edge tile, mode 1. Required: exactly 1 output (value 1); tile_done still after 24 accepts; out_cnt=1.
4. Scenario 1 with out_ready toggling 1,0,1,0 and random in_valid gaps. Required: the same 16 words in order with no duplicates; in_ready=0 whenever out_valid && !out_ready.
5. `start` pulsed with base (2,2,4) at beat 5 of a busy tile. Required: ignored, output identical to scenario 1. Then reset at beat 10: all outputs go to 0, no tile_done; a following start runs scenario 1 cleanly.
